// File: rtl/cpu_run_ctrl.sv
// Run controller for CPU cores: holds core resets, releases them staggered, then
// times the run until every core halts (or any core, with CPU_RUN_CTRL_ANY_HALT_EN) or the budget expires.
module cpu_run_ctrl #(
  parameter int N_CORES    = 1,
  parameter int RST_CYCLES = 2,
  parameter int STAGGER    = 0,
  parameter int MAX_CYCLES = 25,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_CORES-1:0] halt_in,
  output logic [N_CORES-1:0] core_rst_n,
  output logic               running,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [N_CORES-1:0] halted_mask,
  output logic [2:0]         fsm_state
);

  // Handshake: start is a level sampled only in IDLE or DONE; done is a level that
  // stays high (with timeout/cycle_count/halted_mask frozen) until the next sampled start.
  typedef enum logic [2:0] {IDLE, RESET, RELEASE, RUN, DONE} state_t;

  localparam int REL_MAX = (N_CORES - 1) * STAGGER;
  localparam int REL_W   = (REL_MAX > 0) ? $clog2(REL_MAX + 1) : 1;
  localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
  localparam logic [63:0]      BUDGET_LAST = 64'(MAX_CYCLES) - 64'd1;
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [REL_W-1:0]     rel_q, rel_d;
  logic [N_CORES-1:0]   crn_d, mask_d;
  logic [CNT_W-1:0]     cnt_d;
  logic                 to_d;
  logic                 halt_hit;
  int                   rel_next;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    rel_d    = rel_q;
    crn_d    = core_rst_n;
    cnt_d    = cycle_count;
    mask_d   = halted_mask;
    to_d     = timeout;
    halt_hit = 1'b0;
    rel_next = int'(rel_q) + 1;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RESET;
          hold_d  = HOLD_W'(RST_CYCLES);
          cnt_d   = '0;
          mask_d  = '0;
          to_d    = 1'b0;
        end
      end
      RESET: begin
        if (hold_q == HOLD_W'(1)) begin
          state_d = RELEASE;
          rel_d   = '0;
          for (int i = 0; i < N_CORES; i++) crn_d[i] = (i * STAGGER == 0);
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      RELEASE: begin
        // The last core rose on the previous edge: one settled cycle, then RUN.
        if (core_rst_n[N_CORES-1]) begin
          state_d = RUN;
        end else begin
          rel_d = REL_W'(rel_next);
          for (int i = 0; i < N_CORES; i++) begin
            if (i * STAGGER <= rel_next) crn_d[i] = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_d  = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + 1'b1;
        mask_d = halted_mask | halt_in;
`ifdef CPU_RUN_CTRL_ANY_HALT_EN
        halt_hit = |mask_d;
`else
        halt_hit = &mask_d;
`endif
        // Halt is checked first so a halt on the last budget cycle is not a timeout.
        if (halt_hit) begin
          state_d = DONE;
          to_d    = 1'b0;
        end else if ((MAX_CYCLES != 0) && (64'(cycle_count) == BUDGET_LAST)) begin
          state_d = DONE;
          to_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_d != RELEASE) && (state_d != RUN)) crn_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      rel_q       <= '0;
      core_rst_n  <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      halted_mask <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rel_q       <= rel_d;
      core_rst_n  <= crn_d;
      running     <= (state_d == RUN);
      done        <= (state_d == DONE);
      timeout     <= to_d;
      cycle_count <= cnt_d;
      halted_mask <= mask_d;
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: randomized halt schedules, expected results from a
// closed-form run model pushed to queues and checked by an independent monitor.
module tb_cpu_run_ctrl;
  localparam int NC    = 3;
  localparam int RSTC  = 2;
  localparam int STG   = 2;
  localparam int MAXC  = 20;
  localparam int CW    = 16;
  localparam int PRE   = RSTC + (NC - 1) * STG;
  localparam int NEVER = 1000;
  localparam int DW    = 49 + NC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [NC-1:0] halt_in = '0;
  logic [NC-1:0] core_rst_n, halted_mask;
  logic          running, done, timeout;
  logic [CW-1:0] cycle_count;
  logic [2:0]    fsm_state;

  cpu_run_ctrl #(
    .N_CORES(NC), .RST_CYCLES(RSTC), .STAGGER(STG), .MAX_CYCLES(MAXC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt_in(halt_in),
    .core_rst_n(core_rst_n), .running(running), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .halted_mask(halted_mask), .fsm_state(fsm_state)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int start_cyc = 0;
  bit mon_en = 1'b0;
  logic [23:0]   rel_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // run model: completion is the last (or first) halt, capped at the budget's last cycle
  function automatic void model(input int h[NC], output int t_end, output bit to,
                                output logic [NC-1:0] m);
    int hit;
`ifdef CPU_RUN_CTRL_ANY_HALT_EN
    hit = NEVER;
    for (int i = 0; i < NC; i++) if (h[i] < hit) hit = h[i];
`else
    hit = 0;
    for (int i = 0; i < NC; i++) if (h[i] > hit) hit = h[i];
`endif
    if (hit > MAXC - 1) begin
      t_end = MAXC - 1;
      to    = 1'b1;
    end else begin
      t_end = hit;
      to    = 1'b0;
    end
    for (int i = 0; i < NC; i++) m[i] = (h[i] <= t_end);
  endfunction

  task automatic push_releases();
    for (int i = 0; i < NC; i++) rel_q.push_back({8'(i), 16'(RSTC + i * STG)});
  endtask

  // driver: one full run; halt pulses land on RUN cycle h[i], junk elsewhere is ignored
  task automatic do_run(input int h[NC]);
    int t_end, k;
    bit to;
    logic [NC-1:0] m;
    model(h, t_end, to, m);
    push_releases();
    exp_q.push_back({to, m, 16'(t_end + 1), 16'(t_end + 1), 16'(PRE + 2 + t_end)});
    start = 1'b1;
    halt_in = NC'($urandom);
    start_cyc = cyc + 1;
    @(negedge clk);
    chk("start_count_clear", cycle_count, 0);
    chk("start_mask_clear", halted_mask, 0);
    chk("start_timeout_clear", timeout, 0);
    chk("start_done_low", done, 0);
    chk("start_cores_held", core_rst_n, 0);
    for (int mm = 0; mm <= PRE + 1 + t_end; mm++) begin
      if (mm > 0) @(negedge clk);
      k = mm - PRE - 1;
      start = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NC; i++) begin
        if (k < 0)          halt_in[i] = 1'($urandom);
        else if (h[i] == k) halt_in[i] = 1'b1;
        else if (h[i] < k)  halt_in[i] = 1'($urandom);
        else                halt_in[i] = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    halt_in = NC'($urandom);
    repeat ($urandom_range(2, 6)) begin
      @(negedge clk);
      halt_in = NC'($urandom);
    end
    chk("hold_done", done, 1);
    chk("hold_running", running, 0);
    chk("hold_count", cycle_count, 16'(t_end + 1));
    chk("hold_mask", halted_mask, m);
    chk("hold_timeout", timeout, to);
    chk("hold_cores_held", core_rst_n, 0);
  endtask

  // driver: start a run and assert reset during RUN cycle k_abort
  task automatic do_abort(input int k_abort);
    push_releases();
    start = 1'b1;
    halt_in = '0;
    start_cyc = cyc + 1;
    for (int mm = 0; mm <= PRE + 1 + k_abort; mm++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_pre_count", cycle_count, k_abort);
    chk("abort_pre_running", running, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_running", running, 0);
    chk("abort_count", cycle_count, 0);
    chk("abort_cores_held", core_rst_n, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    chk("abort_idle_held", core_rst_n, 0);
    chk("abort_idle_running", running, 0);
  endtask

  // scoreboard monitor
  logic [NC-1:0] prev_crn;
  logic          prev_done, prev_run;
  int            run_len = 0;
  logic [23:0]   r;
  logic [DW-1:0] e;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NC; i++) begin
        if (core_rst_n[i] === 1'b1 && prev_crn[i] !== 1'b1) begin
          if (rel_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL release_unexpected: core %0d rose, no release expected", i);
          end else begin
            r = rel_q.pop_front();
            chk("release_core", i, r[23:16]);
            chk("release_offset", cyc - start_cyc, r[15:0]);
          end
        end
      end
      if (running === 1'b1 && prev_run !== 1'b1) run_len = 0;
      if (running === 1'b1) run_len++;
      if (done === 1'b1 && prev_done !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: done rose with no run outstanding");
        end else begin
          e = exp_q.pop_front();
          chk("done_timeout", timeout, e[DW-1]);
          chk("done_mask", halted_mask, e[DW-2 -: NC]);
          chk("done_count", cycle_count, e[47:32]);
          chk("done_run_len", run_len, e[31:16]);
          chk("done_offset", cyc - start_cyc, e[15:0]);
          chk("done_cores_held", core_rst_n, 0);
        end
      end
    end
    prev_crn  = core_rst_n;
    prev_done = done;
    prev_run  = running;
  end

  int dir_tab [6][NC] = '{
    '{3, 7, 5},
    '{NEVER, NEVER, NEVER},
    '{2, NEVER, 5},
    '{2, 10, MAXC - 1},
    '{0, 0, 0},
    '{MAXC - 1, MAXC - 1, MAXC}
  };

  initial begin
    int h[NC];
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_cores_held", core_rst_n, 0);
    chk("reset_running", running, 0);
    chk("reset_done", done, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_count", cycle_count, 0);
    chk("reset_mask", halted_mask, 0);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    for (int d = 0; d < 6; d++) begin
      h = dir_tab[d];
      do_run(h);
    end
    do_abort(4);
    for (int n = 0; n < 15; n++) begin
      for (int i = 0; i < NC; i++)
        h[i] = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, MAXC + 4));
      do_run(h);
    end

    repeat (4) @(negedge clk);
    chk("leftover_done", exp_q.size(), 0);
    chk("leftover_release", rel_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
